// File: rtl/updown_event_encoder_if.sv
// Event stream handshake between the up/down encoder (master) and the AER bus side (slave).
interface updown_event_encoder_if #(
    parameter int unsigned TS_WIDTH = 12
);
    logic                ev_valid;
    logic                ev_ready;
    logic [TS_WIDTH:0]   ev_data;

    modport master (
        output ev_valid,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        output ev_ready
    );
endinterface

// File: rtl/updown_event_encoder.sv
// Converts up/down modulator codes into timestamped polarity events, buffers them in a FIFO
// and keeps a saturating signed integrator of the event stream.
module updown_event_encoder #(
    parameter int unsigned TS_WIDTH  = 12,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ACC_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    updown_event_encoder_if.master         ev_if,
    input  logic [1:0]                     i_toggle,
    input  logic                           i_clear,
    output logic signed [ACC_WIDTH-1:0]    o_level,
    output logic [$clog2(DEPTH):0]         o_fifo_count,
    output logic                           o_overflow,
    output logic                           o_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [1:0]                  r_prev;
    logic [TS_WIDTH-1:0]         r_ts;
    logic [TS_WIDTH:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W:0]              r_count;
    logic signed [ACC_WIDTH-1:0] r_level;
    logic                        r_overflow;
    logic                        r_err;

    logic                        w_is_up;
    logic                        w_is_down;
    logic                        w_event;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_illegal;
    logic signed [ACC_WIDTH-1:0] w_lvl_max;
    logic signed [ACC_WIDTH-1:0] w_lvl_min;
    logic signed [ACC_WIDTH-1:0] w_level_d;
    logic [PTR_W:0]              w_count_d;

    assign w_is_up   = (i_toggle == 2'b10);
    assign w_is_down = (i_toggle == 2'b01);
    assign w_illegal = (i_toggle == 2'b11);
    // Only the leading edge of an UP/DOWN code is an event; held codes are ignored.
    assign w_event   = (w_is_up || w_is_down) && (i_toggle != r_prev);

    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_pop     = (r_count != '0) && ev_if.ev_ready;
    assign w_push    = w_event && (!w_full || w_pop);
    assign w_drop    = w_event && w_full && !w_pop;

    assign w_lvl_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign w_lvl_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    always_comb begin
        w_level_d = r_level;
        if (i_clear) begin
            w_level_d = '0;
        end else if (w_event) begin
            if (w_is_up && (r_level != w_lvl_max)) begin
                w_level_d = r_level + ACC_WIDTH'(1);
            end else if (w_is_down && (r_level != w_lvl_min)) begin
                w_level_d = r_level - ACC_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_d = r_count - (PTR_W+1)'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= 2'b00;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_prev  <= i_toggle;
            r_ts    <= r_ts + TS_WIDTH'(1);
            r_count <= w_count_d;
            r_level <= w_level_d;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_is_up, r_ts};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Clear wins over a same-cycle set of either sticky flag.
            if (i_clear) begin
                r_overflow <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign ev_if.ev_valid = (r_count != '0);
    assign ev_if.ev_data  = r_mem[r_rd_ptr];
    assign o_level        = r_level;
    assign o_fifo_count   = r_count;
    assign o_overflow     = r_overflow;
    assign o_err          = r_err;
endmodule

// File: doc/updown_event_encoder.md
# updown_event_encoder

Downstream consumer of the up/down delta-modulator output in the neuromorphic front end. Takes the 2-bit up/down `toggle` code, turns each new UP/DOWN assertion into a timestamped polarity event, and buffers events in a small FIFO. The FIFO drains over a valid/ready handshake toward the AER event bus. The block also keeps a saturating signed integrator of the event stream, which gives a reconstructed level for monitoring.

## Interface
- `TS_WIDTH`, 12: timestamp counter width.
- `DEPTH`, 8: event FIFO depth. Must be a power of 2, at least 2.
- `ACC_WIDTH`, 8: width of the signed level integrator.

- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronous to `clk`.
- `toggle` input 2: up/down code from the modulator. 2'b10 = UP, 2'b01 = DOWN, 2'b00 = idle, 2'b11 = illegal.
- `clear` input 1: synchronous clear of `level`, `overflow` and `err`.
- `ev_ready` input 1: downstream accepts the head event.
- `ev_valid` output 1: head event present.
- `ev_data` output TS_WIDTH+1: event word. Bit [TS_WIDTH] is polarity (1 = UP, 0 = DOWN). Bits [TS_WIDTH-1:0] hold the timestamp.
- `level` output ACC_WIDTH: signed, two's complement integrated level.
- `fifo_count` output $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` output 1: sticky flag, set when an event was dropped because the FIFO was full.
- `err` output 1: sticky flag, set when an illegal code was sampled.

## Operation
- **Input sampling:** `toggle` is sampled every cycle into `prev` (reset value 2'b00).
- **Event detection:** an event is detected in a cycle when `toggle` is in {2'b10, 2'b01} and `toggle != prev`.
  - A held code produces exactly one event.
  - A direct change 10→01 or 01→10 produces a new event.
  - 00 and 11 never produce events.
  - 11 sets `err`. `prev` is still updated to 11.
- **Timestamp:** a free-running counter `ts` runs from reset value 0 and increments every cycle. It wraps from 2^TS_WIDTH−1 to 0 with no flag. An event captures the `ts` value of its detection cycle.
- **FIFO write:** a detected event is written at the detection edge if the FIFO is not full.
- **FIFO full:**
  - If the FIFO is full and no pop happens that cycle, the event is dropped and `overflow` is set.
  - If the FIFO is full and a pop happens the same cycle, the push is accepted and `fifo_count` stays at DEPTH.
- **Handshake:**
  - A pop occurs when `ev_valid && ev_ready` at a rising edge.
  - `ev_data` and `ev_valid` are stable while `ev_valid && !ev_ready`.
  - `ev_valid` equals (`fifo_count` != 0).
  - Events leave the FIFO in order, with no reordering or duplication.
- **Integrator:**
  - Every detected event updates `level`, including events dropped at a full FIFO.
  - UP adds +1 and saturates at 2^(ACC_WIDTH−1)−1.
  - DOWN adds −1 and saturates at −2^(ACC_WIDTH−1).
  - Saturation does not set `overflow`.
- **Clear:**
  - `clear` forces `level` to 0 and clears `overflow` and `err`. This takes priority over an event in the same cycle.
  - `clear` does not affect the FIFO, `ts`, `prev`, or enqueueing of that same-cycle event.
- **Reset values:**
  - `ev_valid` = 0, `ev_data` = 0, `level` = 0, `fifo_count` = 0, `overflow` = 0, `err` = 0.
  - Internally: `ts` = 0, `prev` = 2'b00, FIFO pointers = 0.
- **Reset mid-operation:** all buffered events are discarded. No partial transfer is considered accepted.

## Timing
- Detection to visibility is 1 cycle. An event detected in cycle N is written at the end of N.
  - With the FIFO previously empty, `ev_valid` = 1 and `ev_data` shows the event in cycle N+1.
  - `level` reflects the event in cycle N+1.
- There is no combinational path from `toggle` to any output.
- There is no combinational path from `ev_ready` to `ev_valid` or `ev_data`.
- Throughput: one event accepted per cycle, and one event drained per cycle when `ev_ready` is held high.
- `overflow` and `err` become visible 1 cycle after the causing edge.

## Test plan
- **Basic capture:** reset, then hold `toggle` = 00 for 3 cycles, then 10 for 10 cycles, with `ev_ready` = 1. Expect exactly one event: `ev_data` = {1, ts = 3}, visible one cycle later for one cycle. `level` goes 0→1 and stays there.
- **Direct polarity switch:** drive `toggle` 10→01→10 on consecutive cycles with `ev_ready` = 1. Expect three events with polarity 1, 0, 1 and consecutive timestamps. Final `level` = 1.
- **Backpressure and overflow:** with `ev_ready` = 0 and DEPTH = 8, generate 9 alternating events.
  - Expect `fifo_count` = 8, `ev_valid` held, `ev_data` stable at the first event, and `overflow` = 1 after the 9th event.
  - `level` reflects all 9 events.
  - Raise `ev_ready`: 8 events drain in order, then `ev_valid` = 0.
- **Full with simultaneous pop:** fill to 8, then assert `ev_ready` in the same cycle as a new event. Expect `fifo_count` to stay 8, no `overflow`, and the new event to come out last.
- **Saturation, illegal code and clear:** with ACC_WIDTH = 8, apply 130 UP events.
  - Expect `level` = 127.
  - Drive `toggle` = 11: `err` = 1 and no event.
  - Pulse `clear` together with a DOWN event: `level` = 0, `err` = 0, `overflow` = 0, and the DOWN event is still enqueued.
- **Reset mid-stream:** with 4 events buffered, assert `rst_n` low asynchronously between edges. All outputs go to their reset values immediately. After release, `ts` restarts at 0.
